// File: rtl/seq_bam_mult.sv
// seq_bam_mult: sequential broken-array multiplier, one partial-product row per clock.
// Define SEQ_BAM_RUNTIME_CUT_EN to expose h_cut/v_cut; otherwise H_DEF/V_DEF are fixed.
module seq_bam_mult #(
    parameter int N     = 8,
    parameter int H_DEF = 3,
    parameter int V_DEF = 8,
    parameter int CW    = $clog2(2*N)+1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SEQ_BAM_RUNTIME_CUT_EN
    input  logic [CW-1:0]  h_cut,
    input  logic [CW-1:0]  v_cut,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int JW = $clog2(N);
    localparam logic [CW-1:0] LN   = CW'(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);
    state_t         r_state, w_next;
    logic [N-1:0]   r_a, r_b, w_row;
    logic [CW-1:0]  r_j, r_v, w_h, w_v;
    logic [2*N-1:0] r_acc;
`ifdef SEQ_BAM_RUNTIME_CUT_EN
    assign w_h = h_cut;
    assign w_v = v_cut;
`else
    assign w_h = CW'(H_DEF);
    assign w_v = CW'(V_DEF);
`endif
    // Row j keeps a[i] only where column i+j reaches the vertical cut
    always_comb begin
        w_row = '0;
        for (int i = 0; i < N; i++)
            w_row[i] = r_a[i] & r_b[r_j[JW-1:0]] & ((i + int'(r_j)) >= int'(r_v));
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = (w_h < LN) ? RUN : DONE;
            RUN:     if (r_j == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_j   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_v   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_v   <= w_v;
            r_j   <= w_h;
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_acc <= r_acc + ({{N{1'b0}}, w_row} << r_j);
            r_j   <= r_j + 1'b1;
        end
    end
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign p         = r_acc;
endmodule

// File: tb/tb_seq_bam_mult.sv
// tb_seq_bam_mult: directed and random checks of seq_bam_mult against a bit-level sum model.
`timescale 1ns/1ps
module tb_seq_bam_mult;
    localparam int N = 8, CW = $clog2(2*N)+1, H_DEF = 3, V_DEF = 8;
    logic clk = 1'b0, rst, in_valid, out_ready, in_ready, out_valid;
    logic [N-1:0] a, b;
    logic [2*N-1:0] p;
`ifdef SEQ_BAM_RUNTIME_CUT_EN
    logic [CW-1:0] h_cut, v_cut;
`endif
    int checks = 0, fails = 0, cur_h = H_DEF, cur_v = V_DEF;
    always #5 clk = ~clk;

    seq_bam_mult #(.N(N), .H_DEF(H_DEF), .V_DEF(V_DEF), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SEQ_BAM_RUNTIME_CUT_EN
        .h_cut(h_cut), .v_cut(v_cut),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    function automatic logic [2*N-1:0] model(logic [N-1:0] x, logic [N-1:0] y, int h, int v);
        int s = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (x[i] && y[j] && j >= h && i + j >= v) s += 1 << (i + j);
        return (2*N)'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input int h, input int v);
        int k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk("in_ready_before_req", in_ready, 1);
        a = x; b = y; cur_h = h; cur_v = v;
`ifdef SEQ_BAM_RUNTIME_CUT_EN
        h_cut = CW'(h); v_cut = CW'(v);
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom);
`ifdef SEQ_BAM_RUNTIME_CUT_EN
        h_cut = CW'($urandom); v_cut = CW'($urandom);
`endif
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk({tag, "_latency"}, k, (cur_h < N) ? N - cur_h : 0);
    endtask

    task automatic finish_op(input string tag, input logic [2*N-1:0] exp);
        wait_valid(tag);
        chk({tag, "_p"}, p, exp);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            chk({tag, "_p_hold"}, p, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] x, y;
        int rh, rv;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef SEQ_BAM_RUNTIME_CUT_EN
        h_cut = '0; v_cut = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_p", p, 0);

        issue(8'd255, 8'd255, 3, 8); finish_op("cut_255x255", 16'd62208);
        issue(8'd200, 8'd3,   3, 8); finish_op("cut_200x3",   16'd0);
        issue(8'd16,  8'd16,  3, 8); finish_op("cut_16x16",   16'd256);
        issue(8'd15,  8'd16,  3, 8); finish_op("cut_15x16",   16'd0);
`ifdef SEQ_BAM_RUNTIME_CUT_EN
        issue(8'd255, 8'd255, 0, 0);  finish_op("exact_255x255", 16'd65025);
        issue(8'd13,  8'd11,  0, 0);  finish_op("exact_13x11",   16'd143);
        issue(8'd255, 8'd255, 8, 0);  finish_op("h8_zero",       16'd0);
        issue(8'd77,  8'd99,  20, 0); finish_op("h20_zero",      16'd0);
        issue(8'd255, 8'd255, 0, 15); finish_op("v15_zero",      16'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            x = N'($urandom); y = N'($urandom);
`ifdef SEQ_BAM_RUNTIME_CUT_EN
            rh = $urandom_range(0, 17); rv = $urandom_range(0, 17);
`else
            rh = H_DEF; rv = V_DEF;
`endif
            issue(x, y, rh, rv);
            finish_op("random", model(x, y, rh, rv));
        end

        issue(8'd255, 8'd255, 3, 8);
        wait_valid("bp");
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0];
            a = N'($urandom); b = N'($urandom);
            @(posedge clk); #1;
            chk("bp_p_stable", p, 62208);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_high", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_released", out_valid, 0);
        issue(8'd13, 8'd11, 3, 8);
        finish_op("after_bp", model(8'd13, 8'd11, 3, 8));

        issue(8'd255, 8'd255, 3, 8);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_p", p, 0);
        issue(8'd255, 8'd255, 3, 8);
        finish_op("after_rst", 16'd62208);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
